// File: rtl/prog_pkg.sv
// prog_pkg: program-memory geometry shared by the processor, program memory and loader,
// plus the loader state encoding (CHECK only exists with PROGRAM_LOADER_CHECKSUM_EN).
package prog_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_RUN   = 2'd3
   } load_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd3
   } load_state_e;
`endif

endpackage

// File: rtl/prog_checksum.sv
// prog_checksum: running modulo-2^DATA_W sum of the image bytes, cleared at each load start.
// Only instantiated when PROGRAM_LOADER_CHECKSUM_EN is defined.
module prog_checksum
   import prog_pkg::*;
#(
   parameter int SUM_W = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             add_i,
   input  logic [SUM_W-1:0] data_i,
   output logic [SUM_W-1:0] sum_o
);

   logic [SUM_W-1:0] sum_q;
   logic [SUM_W-1:0] sum_d;

   // Carry out of the top bit is dropped on purpose: the check byte is a modulo sum.
   assign sum_d = sum_q + data_i;

   // Accumulator; clear has priority over add.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= {SUM_W{1'b0}};
      end else if (clear_i) begin
         sum_q <= {SUM_W{1'b0}};
      end else if (add_i) begin
         sum_q <= sum_d;
      end else begin
         sum_q <= sum_q;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// program_loader: writes a valid/ready byte stream sequentially into program memory and holds
// the processor (cpu_run low) until a full image is loaded. Option: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import prog_pkg::*;
#(
   parameter int IMG_ADDR_W = ADDR_W,
   parameter int IMG_DATA_W = DATA_W,
   parameter int IMG_DEPTH  = DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [IMG_DATA_W-1:0] in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [IMG_ADDR_W-1:0] wr_addr,
   output logic [IMG_DATA_W-1:0] wr_data,
   output logic                  cpu_run,
   output logic                  load_done,
   output logic                  load_err,
   output logic [IMG_ADDR_W:0]   byte_cnt
);

   localparam int CNT_W = IMG_ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   load_state_e           state_q;
   logic                  in_ready_q;
   logic                  wr_en_q;
   logic [IMG_ADDR_W-1:0] wr_addr_q;
   logic [IMG_DATA_W-1:0] wr_data_q;
   logic                  cpu_run_q;
   logic                  load_done_q;
   logic [CNT_W-1:0]      byte_cnt_q;

   logic                  accept_d;
   logic [CNT_W-1:0]      byte_cnt_d;

   assign accept_d   = in_valid & in_ready_q;
   assign byte_cnt_d = byte_cnt_q + CNT_ONE;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic                  load_err_q;
   logic                  sum_add_d;
   logic [IMG_DATA_W-1:0] sum_d;

   // Only image bytes feed the sum; the trailing check byte and any byte under start do not.
   assign sum_add_d = accept_d & (state_q == ST_LOAD) & ~start;

   prog_checksum #(
      .SUM_W   (IMG_DATA_W)
   ) u_checksum (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (start),
      .add_i   (sum_add_d),
      .data_i  (in_data),
      .sum_o   (sum_d)
   );

   assign load_err = load_err_q;
`else
   assign load_err = 1'b0;
`endif

   // Loader FSM with every output registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= {IMG_ADDR_W{1'b0}};
         wr_data_q   <= {IMG_DATA_W{1'b0}};
         cpu_run_q   <= 1'b0;
         load_done_q <= 1'b0;
         byte_cnt_q  <= {CNT_W{1'b0}};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         load_err_q  <= 1'b0;
`endif
      end else begin
         wr_en_q     <= 1'b0;
         load_done_q <= 1'b0;
         if (start) begin
            // Restart wins over everything, including a byte offered in the same cycle.
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            cpu_run_q  <= 1'b0;
            byte_cnt_q <= {CNT_W{1'b0}};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            load_err_q <= 1'b0;
`endif
         end else begin
            case (state_q)
               ST_IDLE: begin
                  in_ready_q <= 1'b0;
                  cpu_run_q  <= 1'b0;
               end
               ST_LOAD: begin
                  if (accept_d) begin
                     wr_en_q    <= 1'b1;
                     wr_addr_q  <= byte_cnt_q[IMG_ADDR_W-1:0];
                     wr_data_q  <= in_data;
                     byte_cnt_q <= byte_cnt_d;
                     if (byte_cnt_q == LAST_CNT) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_q     <= ST_CHECK;
`else
                        state_q     <= ST_RUN;
                        in_ready_q  <= 1'b0;
                        cpu_run_q   <= 1'b1;
                        load_done_q <= 1'b1;
`endif
                     end else begin
                        state_q <= ST_LOAD;
                     end
                  end else begin
                     state_q <= ST_LOAD;
                  end
               end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               ST_CHECK: begin
                  if (accept_d) begin
                     in_ready_q <= 1'b0;
                     if (in_data == sum_d) begin
                        state_q     <= ST_RUN;
                        cpu_run_q   <= 1'b1;
                        load_done_q <= 1'b1;
                     end else begin
                        state_q    <= ST_IDLE;
                        cpu_run_q  <= 1'b0;
                        load_err_q <= 1'b1;
                     end
                  end else begin
                     state_q <= ST_CHECK;
                  end
               end
`endif
               ST_RUN: begin
                  in_ready_q <= 1'b0;
                  cpu_run_q  <= 1'b1;
               end
               default: begin
                  state_q    <= ST_IDLE;
                  in_ready_q <= 1'b0;
                  cpu_run_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign cpu_run   = cpu_run_q;
   assign load_done = load_done_q;
   assign byte_cnt  = byte_cnt_q;

endmodule
